// File: rtl/meas_wr_arbiter.sv
// meas_wr_arbiter: round-robin drain of per-channel measure results into the single regfile write port.
//   Each channel owns a one-entry holding buffer; one buffered result is written per cycle.
//   Ports: clk_i/rst_n_i (sys_clk, async active-low reset); raw_wr_en_i/raw_wr_data_i per-channel
//   result strobes and data; reg_wr_en_o/reg_wr_data_o/reg_wr_ch_o registered regfile write;
//   pend_o buffer valid flags; ovf_clr_i/ovf_o sticky drop flags.
//   Define ARB_OVF_FLAG_EN to build the sticky overflow flags; otherwise ovf_o is tied low.
module meas_wr_arbiter #(
    parameter int CH_NUM = 5,
    parameter int DATA_W = 64,
    parameter int CH_W   = $clog2(CH_NUM)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [CH_NUM-1:0] raw_wr_en_i,
    input  logic [DATA_W-1:0] raw_wr_data_i [CH_NUM],
    output logic              reg_wr_en_o,
    output logic [DATA_W-1:0] reg_wr_data_o,
    output logic [CH_W-1:0]   reg_wr_ch_o,
    output logic [CH_NUM-1:0] pend_o,
    input  logic              ovf_clr_i,
    output logic [CH_NUM-1:0] ovf_o
);
    logic [CH_NUM-1:0] buf_vld;
    logic [DATA_W-1:0] buf_data [CH_NUM];
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   gnt_idx;
    logic [CH_W-1:0]   scan;
    logic              gnt_vld;
    logic [CH_NUM-1:0] gnt_oh;
    logic [CH_NUM-1:0] ovf_evt;

    // First valid buffer found walking from rr_ptr with wrap-around.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        scan    = '0;
        for (int j = 0; j < CH_NUM; j++) begin
            scan = CH_W'((int'(rr_ptr) + j) % CH_NUM);
            if (!gnt_vld && buf_vld[scan]) begin
                gnt_vld = 1'b1;
                gnt_idx = scan;
            end
        end
    end

    assign gnt_oh  = gnt_vld ? CH_NUM'(1) << gnt_idx : '0;
    // A new strobe is lost only when its buffer is full and not being drained this cycle.
    assign ovf_evt = raw_wr_en_i & buf_vld & ~gnt_oh;
    assign pend_o  = buf_vld;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            buf_vld <= '0;
            for (int i = 0; i < CH_NUM; i++) buf_data[i] <= '0;
        end else begin
            for (int i = 0; i < CH_NUM; i++) begin
                if (raw_wr_en_i[i] && (!buf_vld[i] || gnt_oh[i])) begin
                    buf_vld[i]  <= 1'b1;
                    buf_data[i] <= raw_wr_data_i[i];
                end else if (gnt_oh[i]) begin
                    buf_vld[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rr_ptr        <= '0;
            reg_wr_en_o   <= 1'b0;
            reg_wr_data_o <= '0;
            reg_wr_ch_o   <= '0;
        end else begin
            reg_wr_en_o <= gnt_vld;
            if (gnt_vld) begin
                rr_ptr        <= (gnt_idx == CH_W'(CH_NUM - 1)) ? '0 : gnt_idx + 1'b1;
                reg_wr_data_o <= buf_data[gnt_idx];
                reg_wr_ch_o   <= gnt_idx;
            end
        end
    end

`ifdef ARB_OVF_FLAG_EN
    // A drop at the same edge as a clear wins, so no event is ever hidden.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) ovf_o <= '0;
        else ovf_o <= (ovf_clr_i ? '0 : ovf_o) | ovf_evt;
    end
`else
    logic unused_ovf;
    assign unused_ovf = ^{ovf_clr_i, ovf_evt};
    assign ovf_o      = '0;
`endif
endmodule

// File: tb/tb_meas_wr_arbiter.sv
// tb_meas_wr_arbiter: vector table plus write scoreboard for meas_wr_arbiter.
module tb_meas_wr_arbiter;
    localparam int N = 5;
    localparam int W = 64;
`ifdef ARB_OVF_FLAG_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] raw_en = '0;
    logic [W-1:0] raw_data [N];
    logic         ovf_clr = 1'b0;
    logic         reg_wr_en_o;
    logic [W-1:0] reg_wr_data_o;
    logic [2:0]   reg_wr_ch_o;
    logic [N-1:0] pend_o;
    logic [N-1:0] ovf_o;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        bit              rst;
        logic [4:0]      en;
        logic            clr;
        logic [4:0][31:0] d;
        logic            wen;
        logic [2:0]      wch;
        logic [31:0]     wd;
        logic [4:0]      pend;
        logic [4:0]      ovf;
    } row_t;

    typedef struct packed {
        logic [2:0]  ch;
        logic [63:0] d;
    } wr_t;

    row_t rows[$];
    wr_t  sb[$];
    wr_t  mon_e;

    always #5 clk = ~clk;

    meas_wr_arbiter dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .raw_wr_en_i  (raw_en),
        .raw_wr_data_i(raw_data),
        .reg_wr_en_o  (reg_wr_en_o),
        .reg_wr_data_o(reg_wr_data_o),
        .reg_wr_ch_o  (reg_wr_ch_o),
        .pend_o       (pend_o),
        .ovf_clr_i    (ovf_clr),
        .ovf_o        (ovf_o)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic add(input bit rst, input logic [4:0] en, input logic clr,
                       input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] d3, input logic [31:0] d4,
                       input logic wen, input logic [2:0] wch, input logic [31:0] wd,
                       input logic [4:0] pend, input logic [4:0] ovf);
        row_t r;
        r.rst = rst; r.en = en; r.clr = clr; r.d = {d4, d3, d2, d1, d0};
        r.wen = wen; r.wch = wch; r.wd = wd; r.pend = pend; r.ovf = ovf;
        rows.push_back(r);
    endtask

    task automatic push_wr(input logic [2:0] ch, input logic [63:0] d);
        wr_t e;
        e.ch = ch;
        e.d  = d;
        sb.push_back(e);
    endtask

    task automatic pulse_rst();
        raw_en  = '0;
        ovf_clr = 1'b0;
        rst_n   = 1'b0;
        #2;
        rst_n   = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Every regfile write must match the next expected write, in order.
    always @(negedge clk) begin
        if (rst_n && reg_wr_en_o) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: actual ch=%0d data=%0h required no write", reg_wr_ch_o, reg_wr_data_o);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_ch", 64'(reg_wr_ch_o), 64'(mon_e.ch));
                chk("sb_data", reg_wr_data_o, mon_e.d);
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) raw_data[i] = '0;
        // single request
        add(1, 5'b00100, 0, 0, 0, 32'h0123_4567, 0, 0, 0, 0, 0, 5'b00100, 0);
        add(0, 5'b00000, 0, 0, 0, 0, 0, 0, 1, 2, 32'h0123_4567, 5'b00000, 0);
        add(0, 5'b00000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 0);
        // all channels after reset
        add(1, 5'b11111, 0, 32'h10, 32'h11, 32'h12, 32'h13, 32'h14, 0, 0, 0, 5'b11111, 0);
        add(0, 5'b00000, 0, 0, 0, 0, 0, 0, 1, 0, 32'h10, 5'b11110, 0);
        add(0, 5'b00000, 0, 0, 0, 0, 0, 0, 1, 1, 32'h11, 5'b11100, 0);
        add(0, 5'b00000, 0, 0, 0, 0, 0, 0, 1, 2, 32'h12, 5'b11000, 0);
        add(0, 5'b00000, 0, 0, 0, 0, 0, 0, 1, 3, 32'h13, 5'b10000, 0);
        add(0, 5'b00000, 0, 0, 0, 0, 0, 0, 1, 4, 32'h14, 5'b00000, 0);
        add(0, 5'b00000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 0);
        // round robin: ch3, then ch0+ch4 -> ch4 first; pointer then at 1 -> ch1 before ch0
        add(0, 5'b01000, 0, 0, 0, 0, 32'h33, 0, 0, 0, 0, 5'b01000, 0);
        add(0, 5'b10001, 0, 32'h30, 0, 0, 0, 32'h34, 1, 3, 32'h33, 5'b10001, 0);
        add(0, 5'b00000, 0, 0, 0, 0, 0, 0, 1, 4, 32'h34, 5'b00001, 0);
        add(0, 5'b00011, 0, 32'h40, 32'h41, 0, 0, 0, 1, 0, 32'h30, 5'b00011, 0);
        add(0, 5'b00000, 0, 0, 0, 0, 0, 0, 1, 1, 32'h41, 5'b00001, 0);
        add(0, 5'b00000, 0, 0, 0, 0, 0, 0, 1, 0, 32'h40, 5'b00000, 0);
        add(0, 5'b00000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 0);
        // overflow vs replace
        add(1, 5'b11111, 0, 32'h20, 32'h21, 32'h22, 32'h23, 32'h24, 0, 0, 0, 5'b11111, 0);
        add(0, 5'b10001, 0, 32'hAA, 0, 0, 0, 32'hBB, 1, 0, 32'h20, 5'b11111, 5'b10000);
        add(0, 5'b00000, 0, 0, 0, 0, 0, 0, 1, 1, 32'h21, 5'b11101, 5'b10000);
        add(0, 5'b00000, 0, 0, 0, 0, 0, 0, 1, 2, 32'h22, 5'b11001, 5'b10000);
        add(0, 5'b00000, 0, 0, 0, 0, 0, 0, 1, 3, 32'h23, 5'b10001, 5'b10000);
        add(0, 5'b00000, 0, 0, 0, 0, 0, 0, 1, 4, 32'h24, 5'b00001, 5'b10000);
        add(0, 5'b00000, 0, 0, 0, 0, 0, 0, 1, 0, 32'hAA, 5'b00000, 5'b10000);
        add(0, 5'b00000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b10000);
        add(0, 5'b00000, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000);
        // clear and new drop at the same edge: flag stays set
        add(0, 5'b00110, 0, 0, 32'h51, 32'h52, 0, 0, 0, 0, 0, 5'b00110, 5'b00000);
        add(0, 5'b00100, 1, 0, 0, 32'h5F, 0, 0, 1, 1, 32'h51, 5'b00100, 5'b00100);
        add(0, 5'b00000, 0, 0, 0, 0, 0, 0, 1, 2, 32'h52, 5'b00000, 5'b00100);
        add(0, 5'b00000, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000);
        add(0, 5'b00000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000);

        #2;
        chk("rst_wr_en", 64'(reg_wr_en_o), 64'(0));
        chk("rst_wr_data", reg_wr_data_o, 64'(0));
        chk("rst_wr_ch", 64'(reg_wr_ch_o), 64'(0));
        chk("rst_pend", 64'(pend_o), 64'(0));
        chk("rst_ovf", 64'(ovf_o), 64'(0));
        rst_n = 1'b1;
        step();

        for (int r = 0; r < rows.size(); r++) begin
            if (rows[r].rst) pulse_rst();
            raw_en  = rows[r].en;
            ovf_clr = rows[r].clr;
            for (int i = 0; i < N; i++) raw_data[i] = 64'(rows[r].d[i]);
            if (rows[r].wen) push_wr(rows[r].wch, 64'(rows[r].wd));
            step();
            chk($sformatf("row%0d_wr_en", r), 64'(reg_wr_en_o), 64'(rows[r].wen));
            chk($sformatf("row%0d_pend", r), 64'(pend_o), 64'(rows[r].pend));
            chk($sformatf("row%0d_ovf", r), 64'(ovf_o), 64'(OVF_ON ? rows[r].ovf : 5'b0));
        end
        raw_en  = '0;
        ovf_clr = 1'b0;

        // reset in the middle of a five-deep drain
        pulse_rst();
        raw_en = 5'b11111;
        for (int i = 0; i < N; i++) raw_data[i] = 64'(32'h60 + i);
        step();
        chk("md_pend_full", 64'(pend_o), 64'(5'b11111));
        raw_en = '0;
        push_wr(0, 64'h60);
        step();
        chk("md_wr0", 64'(reg_wr_en_o), 64'(1));
        push_wr(1, 64'h61);
        step();
        chk("md_wr1", 64'(reg_wr_en_o), 64'(1));
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("md_async_wr_en", 64'(reg_wr_en_o), 64'(0));
        chk("md_async_wr_data", reg_wr_data_o, 64'(0));
        chk("md_async_wr_ch", 64'(reg_wr_ch_o), 64'(0));
        chk("md_async_pend", 64'(pend_o), 64'(0));
        chk("md_async_ovf", 64'(ovf_o), 64'(0));
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("md_quiet_wr_en", 64'(reg_wr_en_o), 64'(0));
            chk("md_quiet_pend", 64'(pend_o), 64'(0));
        end
        raw_en      = 5'b10000;
        raw_data[4] = 64'h77;
        push_wr(4, 64'h77);
        step();
        chk("md_ch4_pend", 64'(pend_o), 64'(5'b10000));
        raw_en = '0;
        step();
        chk("md_ch4_wr_en", 64'(reg_wr_en_o), 64'(1));
        chk("md_ch4_ch", 64'(reg_wr_ch_o), 64'(4));
        step();
        chk("md_ch4_done", 64'(reg_wr_en_o), 64'(0));
        @(negedge clk);
        #1;
        chk("sb_empty", 64'(sb.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
